// File: rtl/rasterbar_ramp.sv
// rtl/rasterbar_ramp.sv - per-line rasterbar colour ramp generator (triangle / ramp up / ramp down)
// Optional feature macro: RASTERBAR_SAT_EN (per-channel saturating arithmetic; wraps when undefined)
module rasterbar_ramp #(
  parameter int CHANW = 4,
  parameter int CNTW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               line,
  input  logic [3*CHANW-1:0] base_colr,
  input  logic [3*CHANW-1:0] colr_delta,
  input  logic [CNTW-1:0]    colr_steps,
  input  logic [CNTW-1:0]    colr_lines,
  input  logic [1:0]         mode,
  output logic [3*CHANW-1:0] bar_colr,
  output logic               drawing,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [3*CHANW-1:0] colr_q;
  logic               drawing_q;
  logic               done_q;
  logic [CNTW-1:0]    cnt_step_q;
  logic [CNTW-1:0]    cnt_line_q;
  logic [3*CHANW-1:0] delta_q;
  logic [CNTW-1:0]    step_last_q;
  logic [CNTW-1:0]    line_last_q;
  logic               tri_q;

  logic [3*CHANW-1:0] colr_inc_d;
  logic [3*CHANW-1:0] colr_dec_d;

  // Channel add; clamps at full scale when saturation is built in.
  function automatic logic [CHANW-1:0] chan_add(input logic [CHANW-1:0] a,
                                                input logic [CHANW-1:0] d);
`ifdef RASTERBAR_SAT_EN
    logic [CHANW:0] s;
    s = {1'b0, a} + {1'b0, d};
    chan_add = s[CHANW] ? {CHANW{1'b1}} : s[CHANW-1:0];
`else
    chan_add = a + d;
`endif
  endfunction

  // Channel subtract; clamps at zero when saturation is built in.
  function automatic logic [CHANW-1:0] chan_sub(input logic [CHANW-1:0] a,
                                                input logic [CHANW-1:0] d);
`ifdef RASTERBAR_SAT_EN
    chan_sub = (a < d) ? '0 : a - d;
`else
    chan_sub = a - d;
`endif
  endfunction

  // Candidate next colours, each channel independent (no carry across channels).
  always_comb begin
    colr_inc_d = '0;
    colr_dec_d = '0;
    for (int c = 0; c < 3; c++) begin
      colr_inc_d[c*CHANW +: CHANW] = chan_add(colr_q[c*CHANW +: CHANW], delta_q[c*CHANW +: CHANW]);
      colr_dec_d[c*CHANW +: CHANW] = chan_sub(colr_q[c*CHANW +: CHANW], delta_q[c*CHANW +: CHANW]);
    end
  end

  // Bar FSM: start latches config and wins over line; line advances counters while drawing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      colr_q      <= '0;
      drawing_q   <= 1'b0;
      done_q      <= 1'b0;
      cnt_step_q  <= '0;
      cnt_line_q  <= '0;
      delta_q     <= '0;
      step_last_q <= '0;
      line_last_q <= '0;
      tri_q       <= 1'b0;
    end else if (start) begin
      state_q     <= (mode == 2'b10) ? ST_DOWN : ST_UP;
      colr_q      <= base_colr;
      drawing_q   <= 1'b1;
      done_q      <= 1'b0;
      cnt_step_q  <= '0;
      cnt_line_q  <= '0;
      delta_q     <= colr_delta;
      step_last_q <= (colr_steps == '0) ? '0 : colr_steps - CNTW'(1);
      line_last_q <= (colr_lines == '0) ? '0 : colr_lines - CNTW'(1);
      tri_q       <= (mode == 2'b00) || (mode == 2'b11);
    end else if (line && (state_q == ST_UP || state_q == ST_DOWN)) begin
      if (cnt_line_q != line_last_q) begin
        cnt_line_q <= cnt_line_q + CNTW'(1);
      end else begin
        cnt_line_q <= '0;
        if (cnt_step_q != step_last_q) begin
          cnt_step_q <= cnt_step_q + CNTW'(1);
          colr_q     <= (state_q == ST_UP) ? colr_inc_d : colr_dec_d;
        end else if (state_q == ST_UP && tri_q) begin
          // Turn at the peak: the peak colour is shown for a second segment.
          state_q    <= ST_DOWN;
          cnt_step_q <= '0;
        end else begin
          state_q   <= ST_DONE;
          drawing_q <= 1'b0;
          done_q    <= 1'b1;
          colr_q    <= '0;
        end
      end
    end
  end

  assign bar_colr = colr_q;
  assign drawing  = drawing_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rasterbar_ramp.sv
// tb/tb_rasterbar_ramp.sv - randomized self-checking bench for rasterbar_ramp
module tb_rasterbar_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        line;
  logic [11:0] base_colr;
  logic [11:0] colr_delta;
  logic [3:0]  colr_steps;
  logic [3:0]  colr_lines;
  logic [1:0]  mode;
  logic [11:0] bar_colr;
  logic        drawing;
  logic        done;

  int          n_chk = 0;
  int          n_bad = 0;
  int          line_cnt = 0;
  logic [11:0] exp_q[$];

  rasterbar_ramp #(.CHANW(4), .CNTW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .line       (line),
    .base_colr  (base_colr),
    .colr_delta (colr_delta),
    .colr_steps (colr_steps),
    .colr_lines (colr_lines),
    .mode       (mode),
    .bar_colr   (bar_colr),
    .drawing    (drawing),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Colour after k steps from c, computed directly as base +/- k*delta per channel.
  function automatic logic [11:0] model_colr(input logic [11:0] c, input logic [11:0] d,
                                             input int k, input bit down);
    logic [11:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int v;
      int dd;
      int x;
      v  = int'(c[ch*4 +: 4]);
      dd = int'(d[ch*4 +: 4]);
      x  = down ? v - k * dd : v + k * dd;
`ifdef RASTERBAR_SAT_EN
      if (x < 0) x = 0;
      if (x > 15) x = 15;
`else
      x = x & 15;
`endif
      r[ch*4 +: 4] = x[3:0];
    end
    return r;
  endfunction

  // Expected colour for every line of the bar, indexed by line pulses since start.
  task automatic build_expect(input logic [11:0] b, input logic [11:0] d,
                              input logic [3:0] s, input logic [3:0] l, input logic [1:0] m);
    int          ns;
    int          nl;
    logic [11:0] segs[$];
    logic [11:0] peak;
    ns = (s == 0) ? 1 : int'(s);
    nl = (l == 0) ? 1 : int'(l);
    exp_q.delete();
    if (m == 2'b10) begin
      for (int k = 0; k < ns; k++) segs.push_back(model_colr(b, d, k, 1'b1));
    end else begin
      for (int k = 0; k < ns; k++) segs.push_back(model_colr(b, d, k, 1'b0));
      if (m != 2'b01) begin
        peak = model_colr(b, d, ns - 1, 1'b0);
        for (int j = 0; j < ns; j++) segs.push_back(model_colr(peak, d, j, 1'b1));
      end
    end
    foreach (segs[i]) for (int r = 0; r < nl; r++) exp_q.push_back(segs[i]);
  endtask

  task automatic do_start(input logic [11:0] b, input logic [11:0] d, input logic [3:0] s,
                          input logic [3:0] l, input logic [1:0] m, input bit with_line);
    @(negedge clk);
    base_colr  = b;
    colr_delta = d;
    colr_steps = s;
    colr_lines = l;
    mode       = m;
    start      = 1'b1;
    line       = with_line;
    @(negedge clk);
    start      = 1'b0;
    line       = 1'b0;
    base_colr  = 12'($urandom);
    colr_delta = 12'($urandom);
    colr_steps = 4'($urandom);
    colr_lines = 4'($urandom);
    mode       = 2'($urandom);
    build_expect(b, d, s, l, m);
    line_cnt = 0;
    chk("start_colr", bar_colr, exp_q[0]);
    chk("start_drawing", drawing, 1);
    chk("start_done", done, 0);
  endtask

  task automatic pulse_line();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    line = 1'b1;
    @(negedge clk);
    line = 1'b0;
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_line();
      line_cnt++;
      if (line_cnt < exp_q.size()) begin
        chk("line_colr", bar_colr, exp_q[line_cnt]);
        chk("line_drawing", drawing, 1);
        chk("line_done", done, 0);
      end else begin
        chk("end_colr", bar_colr, 0);
        chk("end_drawing", drawing, 0);
        chk("end_done", done, 1);
      end
    end
  endtask

  task automatic run_full();
    run_lines(exp_q.size() + 2 - line_cnt);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    line       = 1'b0;
    base_colr  = '0;
    colr_delta = '0;
    colr_steps = '0;
    colr_lines = '0;
    mode       = '0;
    repeat (3) @(negedge clk);
    chk("rst_colr", bar_colr, 0);
    chk("rst_drawing", drawing, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Lines while idle are ignored.
    pulse_line();
    pulse_line();
    chk("idle_colr", bar_colr, 0);
    chk("idle_drawing", drawing, 0);
    chk("idle_done", done, 0);

    // Triangle 222 / 111, 3 steps, 2 lines each.
    do_start(12'h222, 12'h111, 4'd3, 4'd2, 2'b00, 1'b0);
    run_lines(4);
    chk("tri_peak_first", bar_colr, 12'h444);
    run_lines(2);
    chk("tri_peak_second", bar_colr, 12'h444);
    run_full();

    // Ramp up into the top of the range.
    do_start(12'hEEE, 12'h111, 4'd4, 4'd1, 2'b01, 1'b0);
    run_full();

    // Ramp down into zero, channels independent.
    do_start(12'h842, 12'h421, 4'd3, 4'd1, 2'b10, 1'b0);
    run_full();

    // Zero steps and zero lines behave as one.
    do_start(12'h5A5, 12'h321, 4'd0, 4'd0, 2'b00, 1'b0);
    run_full();

    // Restart mid-bar with line in the same cycle.
    do_start(12'hABC, 12'h111, 4'd4, 4'd2, 2'b00, 1'b0);
    run_lines(3);
    do_start(12'h123, 12'h101, 4'd3, 4'd2, 2'b11, 1'b1);
    chk("restart_colr", bar_colr, 12'h123);
    run_full();

    // Asynchronous reset in the middle of a down ramp.
    do_start(12'hFFF, 12'h111, 4'd5, 4'd1, 2'b10, 1'b0);
    run_lines(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_colr", bar_colr, 0);
    chk("arst_drawing", drawing, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_line();
    pulse_line();
    chk("post_rst_colr", bar_colr, 0);
    chk("post_rst_drawing", drawing, 0);
    chk("post_rst_done", done, 0);

    // Randomized bars, some aborted by a restart.
    for (int t = 0; t < 40; t++) begin
      do_start(12'($urandom), 12'($urandom), 4'($urandom_range(0, 6)),
               4'($urandom_range(0, 3)), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) run_lines($urandom_range(0, exp_q.size() - 1));
      else run_full();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
